// File: rtl/pkt_rx_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pkt_rx_pkg
// Description : Shared types and widths for the MAC packet RX reader.
// Revision    : 1.0 - initial release
// ============================================================================
package pkt_rx_pkg;

    localparam int DATA_W = 64;
    localparam int MOD_W  = 3;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        READ = 2'd1,
        GAP  = 2'd2
    } rx_state_t;

    typedef struct packed {
        logic [DATA_W-1:0] data;
        logic              sop;
        logic              eop;
        logic [MOD_W-1:0]  mod;
        logic              err;
    } rx_word_t;

endpackage
`default_nettype wire

// File: rtl/pkt_rx_fifo.sv
`default_nettype none
// ============================================================================
// Module      : pkt_rx_fifo
// Description : First-word-fall-through FIFO of rx_word_t with occupancy count.
// Revision    : 1.0 - initial release
// ============================================================================
module pkt_rx_fifo
    import pkt_rx_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   i_push,
    input  rx_word_t               i_data,
    input  logic                   i_pop,
    output rx_word_t               o_data,
    output logic                   o_valid,
    output logic                   o_full,
    output logic [$clog2(DEPTH):0] o_count
);

    localparam int                 c_PTR_W   = $clog2(DEPTH);
    localparam logic [c_PTR_W-1:0] c_PTR_ONE = c_PTR_W'(1);
    localparam logic [c_PTR_W:0]   c_CNT_ONE = (c_PTR_W + 1)'(1);
    localparam logic [c_PTR_W:0]   c_FULL    = (c_PTR_W + 1)'(DEPTH);

    rx_word_t           r_mem [DEPTH];
    logic [c_PTR_W-1:0] r_wr_ptr;
    logic [c_PTR_W-1:0] r_rd_ptr;
    logic [c_PTR_W:0]   r_count;
    logic               w_push;
    logic               w_pop;

    assign o_valid = (r_count != '0);
    assign o_full  = (r_count == c_FULL);
    assign o_count = r_count;
    assign w_pop   = i_pop & o_valid;
    assign w_push  = i_push & (!o_full | w_pop);

    // Head is forced to zero when empty so idle output fields read as 0.
    assign o_data  = o_valid ? r_mem[r_rd_ptr] : '0;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + c_PTR_ONE;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_PTR_ONE;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + c_CNT_ONE;
                2'b01:   r_count <= r_count - c_CNT_ONE;
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= i_data;
        end
    end

endmodule
`default_nettype wire

// File: rtl/pkt_rx_reader.sv
`default_nettype none
// ============================================================================
// Module      : pkt_rx_reader
// Description : Pulls frames from the MAC RX FIFO, checks framing, buffers
//               words onto a valid/ready stream and keeps frame statistics.
// Revision    : 1.0 - initial release
// ============================================================================
module pkt_rx_reader
    import pkt_rx_pkg::*;
#(
    parameter int FIFO_DEPTH = 4
) (
    input  logic              clk_156m25,
    input  logic              reset_156m25,
    input  logic              pkt_rx_avail,
    output logic              pkt_rx_ren,
    input  logic              pkt_rx_val,
    input  logic [DATA_W-1:0] pkt_rx_data,
    input  logic              pkt_rx_sop,
    input  logic              pkt_rx_eop,
    input  logic [MOD_W-1:0]  pkt_rx_mod,
    input  logic              pkt_rx_err,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              out_sop,
    output logic              out_eop,
    output logic              out_err,
    output logic [MOD_W-1:0]  out_mod,
    output logic [31:0]       pkt_cnt,
    output logic [31:0]       err_cnt,
    output logic [15:0]       last_len
);

    localparam int                 c_CNT_W = $clog2(FIFO_DEPTH) + 1;
    localparam logic [c_CNT_W-1:0] c_DEPTH = c_CNT_W'(FIFO_DEPTH);

    rx_state_t          r_state;
    rx_state_t          w_state_next;
    logic               w_ren;
    logic               r_ren_q;
    logic [c_CNT_W-1:0] w_count;
    logic [c_CNT_W-1:0] w_occ;
    logic               w_full;
    logic               w_push;
    logic               w_pop;
    logic               w_valid;
    logic               w_rx_eop;
    rx_word_t           w_in_word;
    rx_word_t           w_head;

    logic               r_in_pkt;
    logic               r_frm_err;
    logic [12:0]        r_word_cnt;
    logic               w_frm_err;
    logic [3:0]         w_mod_bytes;
    logic [15:0]        w_len;
    logic [31:0]        r_pkt_cnt;
    logic [31:0]        r_err_cnt;
    logic [15:0]        r_last_len;

    assign w_rx_eop = pkt_rx_val & pkt_rx_eop;
    // Buffered words plus the one still in flight from last cycle's read.
    assign w_occ    = w_count + c_CNT_W'(r_ren_q);

    always_ff @(posedge clk_156m25) begin
        if (reset_156m25) begin
            r_state <= IDLE;
            r_ren_q <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_ren_q <= w_ren;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_ren        = 1'b0;
        case (r_state)
            IDLE: begin
                if (pkt_rx_avail) begin
                    w_state_next = READ;
                end
            end
            READ: begin
                w_ren = !w_rx_eop && (w_occ < c_DEPTH) && !reset_156m25;
                if (w_rx_eop) begin
                    w_state_next = GAP;
                end
            end
            GAP: begin
                w_state_next = IDLE;
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    assign pkt_rx_ren = w_ren;

    // Framing checker: a missing SOP or a repeated SOP taints the whole frame.
    assign w_push    = pkt_rx_val && (r_state == READ) && !reset_156m25;
    assign w_frm_err = r_frm_err
                     | (r_in_pkt & pkt_rx_sop)
                     | (!r_in_pkt & !pkt_rx_sop);

    assign w_in_word.data = pkt_rx_data;
    assign w_in_word.sop  = pkt_rx_sop | !r_in_pkt;
    assign w_in_word.eop  = pkt_rx_eop;
    assign w_in_word.mod  = pkt_rx_mod;
    assign w_in_word.err  = pkt_rx_eop & (pkt_rx_err | w_frm_err);

    assign w_mod_bytes = (pkt_rx_mod == '0) ? 4'd8 : {1'b0, pkt_rx_mod};
    assign w_len       = {r_word_cnt, 3'b000} + {12'd0, w_mod_bytes};

    always_ff @(posedge clk_156m25) begin
        if (reset_156m25) begin
            r_in_pkt   <= 1'b0;
            r_frm_err  <= 1'b0;
            r_word_cnt <= '0;
            r_last_len <= '0;
        end else if (w_push) begin
            if (pkt_rx_eop) begin
                r_in_pkt   <= 1'b0;
                r_frm_err  <= 1'b0;
                r_word_cnt <= '0;
                r_last_len <= w_len;
            end else begin
                r_in_pkt   <= 1'b1;
                r_frm_err  <= w_frm_err;
                r_word_cnt <= r_word_cnt + 13'd1;
            end
        end
    end

    pkt_rx_fifo #(
        .DEPTH   (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk_156m25),
        .rst     (reset_156m25),
        .i_push  (w_push),
        .i_data  (w_in_word),
        .i_pop   (w_pop),
        .o_data  (w_head),
        .o_valid (w_valid),
        .o_full  (w_full),
        .o_count (w_count)
    );

    assign w_pop = w_valid & out_ready;

    always_ff @(posedge clk_156m25) begin
        if (reset_156m25) begin
            r_pkt_cnt <= '0;
            r_err_cnt <= '0;
        end else if (w_pop && w_head.eop) begin
            r_pkt_cnt <= r_pkt_cnt + 32'd1;
            if (w_head.err) begin
                r_err_cnt <= r_err_cnt + 32'd1;
            end
        end
    end

    assert property (@(posedge clk_156m25) disable iff (reset_156m25) !(w_push && w_full));

    assign out_valid = w_valid;
    assign out_data  = w_head.data;
    assign out_sop   = w_head.sop;
    assign out_eop   = w_head.eop;
    assign out_mod   = w_head.mod;
    assign out_err   = w_head.err;
    assign pkt_cnt   = r_pkt_cnt;
    assign err_cnt   = r_err_cnt;
    assign last_len  = r_last_len;

endmodule
`default_nettype wire

// File: tb/tb_pkt_rx_reader.sv
`default_nettype none
// ============================================================================
// Module      : tb_pkt_rx_reader
// Description : Self-checking bench for pkt_rx_reader with a MAC model and a
//               frame-level reference of the output stream and statistics.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pkt_rx_reader;

    localparam int FIFO_DEPTH = 4;

    typedef struct packed {
        logic [63:0] data;
        logic        sop;
        logic        eop;
        logic [2:0]  mod;
        logic        err;
    } tb_word_t;

    logic        clk_156m25 = 1'b0;
    logic        reset_156m25;
    logic        pkt_rx_avail;
    logic        pkt_rx_ren;
    logic        pkt_rx_val;
    logic [63:0] pkt_rx_data;
    logic        pkt_rx_sop;
    logic        pkt_rx_eop;
    logic [2:0]  pkt_rx_mod;
    logic        pkt_rx_err;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] out_data;
    logic        out_sop;
    logic        out_eop;
    logic        out_err;
    logic [2:0]  out_mod;
    logic [31:0] pkt_cnt;
    logic [31:0] err_cnt;
    logic [15:0] last_len;

    pkt_rx_reader #(.FIFO_DEPTH(FIFO_DEPTH)) dut (
        .clk_156m25   (clk_156m25),
        .reset_156m25 (reset_156m25),
        .pkt_rx_avail (pkt_rx_avail),
        .pkt_rx_ren   (pkt_rx_ren),
        .pkt_rx_val   (pkt_rx_val),
        .pkt_rx_data  (pkt_rx_data),
        .pkt_rx_sop   (pkt_rx_sop),
        .pkt_rx_eop   (pkt_rx_eop),
        .pkt_rx_mod   (pkt_rx_mod),
        .pkt_rx_err   (pkt_rx_err),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_data     (out_data),
        .out_sop      (out_sop),
        .out_eop      (out_eop),
        .out_err      (out_err),
        .out_mod      (out_mod),
        .pkt_cnt      (pkt_cnt),
        .err_cnt      (err_cnt),
        .last_len     (last_len)
    );

    always #5 clk_156m25 = ~clk_156m25;

    int       checks = 0;
    int       errors = 0;
    int       cyc = 0;
    int       rdy_mode = 3;
    tb_word_t mac_q[$];
    tb_word_t exp_q[$];
    int       mac_frames = 0;
    bit       ren_pending = 1'b0;
    bit       m_in_pkt = 1'b0;
    bit       m_bad = 1'b0;
    int       m_words = 0;
    int       exp_pkt = 0;
    int       exp_errc = 0;
    int       exp_len = 0;
    int       ren_cnt = 0;
    int       gap_cnt = 0;
    int       last_gap = 0;
    int       low_run = 0;
    bit       saw_ren = 1'b0;

    task automatic chk(input string tag, input logic [79:0] got, input logic [79:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic add_word(input bit sop, input bit eop, input logic [2:0] mod, input bit err);
        tb_word_t w;
        w.data = {$urandom(), $urandom()};
        w.sop  = sop;
        w.eop  = eop;
        w.mod  = mod;
        w.err  = err;
        mac_q.push_back(w);
        if (eop) mac_frames++;
    endtask

    task automatic add_frame(input int len, input logic [2:0] mod, input bit err, input bit nosop);
        for (int i = 0; i < len; i++) begin
            add_word((i == 0) && !nosop, i == len - 1,
                     (i == len - 1) ? mod : 3'($urandom_range(0, 7)),
                     (i == len - 1) ? err : 1'b0);
        end
    endtask

    // Reference: what the stream should carry for each word accepted while reading.
    task automatic accept(input tb_word_t w);
        tb_word_t e;
        e = w;
        if (!m_in_pkt && !w.sop) begin
            e.sop = 1'b1;
            m_bad = 1'b1;
        end else if (m_in_pkt && w.sop) begin
            m_bad = 1'b1;
        end
        m_words++;
        e.err = w.eop ? (w.err | m_bad) : 1'b0;
        if (w.eop) begin
            exp_len  = 8 * (m_words - 1) + ((w.mod == 3'd0) ? 8 : int'(w.mod));
            m_in_pkt = 1'b0;
            m_bad    = 1'b0;
            m_words  = 0;
        end else begin
            m_in_pkt = 1'b1;
        end
        exp_q.push_back(e);
    endtask

    task automatic clear_model();
        mac_q.delete();
        exp_q.delete();
        mac_frames = 0;
        m_in_pkt   = 1'b0;
        m_bad      = 1'b0;
        m_words    = 0;
        exp_pkt    = 0;
        exp_errc   = 0;
        exp_len    = 0;
    endtask

    task automatic stats_clear();
        ren_cnt  = 0;
        gap_cnt  = 0;
        last_gap = 0;
        low_run  = 0;
        saw_ren  = 1'b0;
    endtask

    task automatic cycle(input bit rst_in, input bit inject);
        tb_word_t w;
        @(negedge clk_156m25);
        cyc++;
        reset_156m25 = rst_in;
        case (rdy_mode)
            0:       out_ready = 1'b1;
            1:       out_ready = ((cyc / 3) % 2) == 0;
            2:       out_ready = ($urandom_range(0, 3) != 0);
            default: out_ready = 1'b0;
        endcase
        chk("pkt_cnt", 80'(pkt_cnt), 80'(exp_pkt));
        chk("err_cnt", 80'(err_cnt), 80'(exp_errc));
        if (ren_pending) begin
            checks++;
            assert (mac_q.size() != 0) else begin
                errors++;
                $error("FAIL read_past_end: observed read with empty MAC queue, expected none");
            end
        end
        if (ren_pending && mac_q.size() != 0) begin
            w = mac_q.pop_front();
            pkt_rx_val  = 1'b1;
            pkt_rx_data = w.data;
            pkt_rx_sop  = w.sop;
            pkt_rx_eop  = w.eop;
            pkt_rx_mod  = w.mod;
            pkt_rx_err  = w.err;
            if (w.eop) mac_frames--;
            if (!rst_in) accept(w);
        end else begin
            pkt_rx_val  = inject;
            pkt_rx_data = {$urandom(), $urandom()};
            pkt_rx_sop  = 1'($urandom_range(0, 1));
            pkt_rx_eop  = 1'($urandom_range(0, 1));
            pkt_rx_mod  = 3'($urandom_range(0, 7));
            pkt_rx_err  = 1'($urandom_range(0, 1));
        end
        pkt_rx_avail = (mac_frames > 0);
        #1;
        if (rst_in) chk("ren_in_reset", 80'(pkt_rx_ren), 80'(0));
        if (pkt_rx_ren) begin
            ren_cnt++;
            checks++;
            assert (!(pkt_rx_val && pkt_rx_eop)) else begin
                errors++;
                $error("FAIL ren_on_eop: observed ren=1 with EOP arriving, expected 0");
            end
            checks++;
            assert (exp_q.size() < FIFO_DEPTH) else begin
                errors++;
                $error("FAIL ren_gating: observed ren=1 at occupancy %0d, expected below %0d",
                       exp_q.size(), FIFO_DEPTH);
            end
            if (saw_ren && low_run > 0) begin
                gap_cnt++;
                last_gap = low_run;
            end
            saw_ren = 1'b1;
            low_run = 0;
        end else if (saw_ren) begin
            low_run++;
        end
        if (out_valid && out_ready && !rst_in) begin
            checks++;
            assert (exp_q.size() != 0) else begin
                errors++;
                $error("FAIL unexpected_word: observed data %0h, expected no word", out_data);
            end
            if (exp_q.size() != 0) begin
                w = exp_q.pop_front();
                chk("stream_word", 80'({out_data, out_sop, out_eop, out_mod, out_err}), 80'(w));
                if (w.eop) begin
                    exp_pkt++;
                    if (w.err) exp_errc++;
                end
            end
        end
        ren_pending = pkt_rx_ren;
        if (rst_in) clear_model();
    endtask

    task automatic run_idle(input int budget);
        int n;
        n = 0;
        while ((mac_q.size() != 0 || ren_pending || exp_q.size() != 0) && n < budget) begin
            cycle(1'b0, 1'b0);
            n++;
        end
        checks++;
        assert (n < budget) else begin
            errors++;
            $error("FAIL timeout: observed %0d cycles, expected fewer than %0d", n, budget);
        end
        repeat (3) cycle(1'b0, 1'b0);
    endtask

    task automatic do_reset();
        cycle(1'b1, 1'b0);
        cycle(1'b1, 1'b0);
        stats_clear();
    endtask

    initial begin
        int n;
        reset_156m25 = 1'b1;
        pkt_rx_avail = 1'b0;
        pkt_rx_val   = 1'b0;
        pkt_rx_data  = '0;
        pkt_rx_sop   = 1'b0;
        pkt_rx_eop   = 1'b0;
        pkt_rx_mod   = '0;
        pkt_rx_err   = 1'b0;
        out_ready    = 1'b0;

        do_reset();
        chk("rst_ren", 80'(pkt_rx_ren), 80'(0));
        chk("rst_valid", 80'(out_valid), 80'(0));
        chk("rst_fields", 80'({out_data, out_sop, out_eop, out_mod, out_err}), 80'(0));
        chk("rst_stats", 80'({pkt_cnt, err_cnt, last_len}), 80'(0));

        // 3-word frame, mod 5
        rdy_mode = 0;
        add_word(1'b1, 1'b0, 3'd0, 1'b0);
        add_word(1'b0, 1'b0, 3'd0, 1'b0);
        add_word(1'b0, 1'b1, 3'd5, 1'b0);
        run_idle(200);
        chk("t1_ren_pulses", 80'(ren_cnt), 80'(3));
        chk("t1_last_len", 80'(last_len), 80'(21));
        chk("t1_pkt_cnt", 80'(pkt_cnt), 80'(1));
        chk("t1_err_cnt", 80'(err_cnt), 80'(0));

        // back-to-back 1-word and 8-word frames, avail held high;
        // ren is low for the EOP-return, GAP and IDLE cycles
        do_reset();
        add_frame(1, 3'd3, 1'b0, 1'b0);
        add_frame(8, 3'd0, 1'b0, 1'b0);
        run_idle(300);
        chk("t2_gap_count", 80'(gap_cnt), 80'(1));
        chk("t2_gap_len", 80'(last_gap), 80'(3));
        chk("t2_ren_pulses", 80'(ren_cnt), 80'(9));
        chk("t2_pkt_cnt", 80'(pkt_cnt), 80'(2));
        chk("t2_last_len", 80'(last_len), 80'(64));

        // 10-word frame with out_ready toggling every 3 cycles
        do_reset();
        rdy_mode = 1;
        add_frame(10, 3'd2, 1'b0, 1'b0);
        run_idle(400);
        chk("t3_ren_pulses", 80'(ren_cnt), 80'(10));
        chk("t3_pkt_cnt", 80'(pkt_cnt), 80'(1));
        chk("t3_last_len", 80'(last_len), 80'(74));

        // MAC error on EOP; an error flag on a non-EOP word is ignored
        do_reset();
        rdy_mode = 0;
        add_word(1'b1, 1'b0, 3'd0, 1'b1);
        add_word(1'b0, 1'b0, 3'd0, 1'b0);
        add_word(1'b0, 1'b1, 3'd0, 1'b1);
        run_idle(200);
        chk("t4_err_cnt", 80'(err_cnt), 80'(1));
        chk("t4_pkt_cnt", 80'(pkt_cnt), 80'(1));
        chk("t4_last_len", 80'(last_len), 80'(24));

        // missing SOP, then a repeated SOP mid-frame
        do_reset();
        add_word(1'b0, 1'b0, 3'd0, 1'b0);
        add_word(1'b0, 1'b1, 3'd4, 1'b0);
        add_word(1'b1, 1'b0, 3'd0, 1'b0);
        add_word(1'b1, 1'b0, 3'd0, 1'b0);
        add_word(1'b0, 1'b1, 3'd6, 1'b0);
        run_idle(300);
        chk("t5_err_cnt", 80'(err_cnt), 80'(2));
        chk("t5_pkt_cnt", 80'(pkt_cnt), 80'(2));
        chk("t5_last_len", 80'(last_len), 80'(22));

        // one-cycle reset with 2 words buffered and a read in flight
        rdy_mode = 3;
        stats_clear();
        add_frame(6, 3'd1, 1'b0, 1'b0);
        n = 0;
        while (!(exp_q.size() == 2 && ren_pending) && n < 50) begin
            cycle(1'b0, 1'b0);
            n++;
        end
        checks++;
        assert (n < 50) else begin
            errors++;
            $error("FAIL t6_fill: observed %0d cycles, expected fewer than 50", n);
        end
        cycle(1'b1, 1'b0);
        rdy_mode = 0;
        cycle(1'b0, 1'b1);
        chk("t6_valid_after_rst", 80'(out_valid), 80'(0));
        chk("t6_len_after_rst", 80'(last_len), 80'(0));
        chk("t6_cnt_after_rst", 80'({pkt_cnt, err_cnt}), 80'(0));
        repeat (3) cycle(1'b0, 1'b0);
        add_frame(4, 3'd1, 1'b0, 1'b0);
        run_idle(200);
        chk("t6_pkt_cnt", 80'(pkt_cnt), 80'(1));
        chk("t6_err_cnt", 80'(err_cnt), 80'(0));
        chk("t6_last_len", 80'(last_len), 80'(25));

        // randomized frames and back-pressure
        do_reset();
        rdy_mode = 2;
        for (int f = 0; f < 20; f++) begin
            add_frame($urandom_range(1, 12), 3'($urandom_range(0, 7)),
                      $urandom_range(0, 3) == 0, $urandom_range(0, 7) == 0);
        end
        run_idle(3000);
        chk("t7_pkt_cnt", 80'(pkt_cnt), 80'(20));
        chk("t7_err_cnt", 80'(err_cnt), 80'(exp_errc));
        chk("t7_last_len", 80'(last_len), 80'(exp_len));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
